// File: rtl/mstr_i2c_fsm.sv
// -----------------------------------------------------------------------------
// mstr_i2c_fsm
// Single-master I2C controller. It accepts one request from local logic, then
// generates START, sends {slave address, RW}, and either:
//   - write: sends a register-address byte followed by a data byte, or
//   - read : receives one data byte and answers it with master NACK.
// Every transaction ends with STOP. A slave NACK is reported on O_ACK_FL.
//
// SCL/SDA outputs are open-drain style (1 = release, 0 = pull low). Pads and
// input synchronisers live outside this block.
//
// Timing: a quarter counter divides CLK by DIV = CLK_FRQ/(4*I2C_FRQ), which
// must be at least 1. Every bus phase (START, each bit slot, STOP) lasts four
// quarters q0..q3.
//
// Optional build macro CLK_STRETCH_EN: when defined, a slave holding SCL low
// during q2/q3 of a bit slot or of STOP freezes the quarter timing until SCL
// reads high. When undefined, I_SCL is ignored and timing is fixed.
//
// O_STATE exposes the FSM state for debug and assertion binding.
// -----------------------------------------------------------------------------
module mstr_i2c_fsm #(
   parameter int DATA_SZ = 8,
   parameter int CLK_FRQ = 50_000_000,
   parameter int I2C_FRQ = 100_000
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               I_START,
   input  logic [DATA_SZ-2:0] I_ADDR_SLV,
   input  logic               I_RW,
   input  logic [DATA_SZ-1:0] I_ADDR_REG,
   input  logic [DATA_SZ-1:0] I_DATA_WR,
   input  logic               I_SCL,
   input  logic               I_SDA,
   output logic               O_SCL,
   output logic               O_SDA,
   output logic [DATA_SZ-1:0] O_DATA_RD,
   output logic               O_BUSY,
   output logic               O_DONE,
   output logic               O_ACK_FL,
   output logic [3:0]         O_STATE
);

   // Quarter-period divider and its counter width (at least one bit).
   localparam int DIV = CLK_FRQ / (4 * I2C_FRQ);
   localparam int QW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(DIV - 1);
   localparam logic [QW-1:0] Q_ONE  = QW'(1);

   // Bit counter runs DATA_SZ down to 0.
   localparam int BW = $clog2(DATA_SZ + 1);
   localparam logic [BW-1:0] BITS  = BW'(DATA_SZ);
   localparam logic [BW-1:0] B_ONE = BW'(1);

   typedef enum logic [3:0] {
      ST_IDLE     = 4'd0,
      ST_START    = 4'd1,
      ST_COMM     = 4'd2,
      ST_ACK_COMM = 4'd3,
      ST_WR       = 4'd4,
      ST_ACK_DATA = 4'd5,
      ST_RD       = 4'd6,
      ST_MSTR_ACK = 4'd7,
      ST_STOP     = 4'd8
   } state_t;

   state_t               r_state;
   logic [QW-1:0]        r_qcnt;
   logic [1:0]           r_phase;
   logic [BW-1:0]        r_bitcnt;
   logic                 r_byte_sel;   // 0: register byte on the wire, 1: data byte
   logic                 r_rw;
   logic [DATA_SZ-1:0]   r_addr_reg;
   logic [DATA_SZ-1:0]   r_data_wr;
   logic [DATA_SZ-1:0]   r_tx;         // outgoing byte, MSB is the bit on the wire
   logic [DATA_SZ-1:0]   r_rx;         // incoming byte, shifted in MSB first
   logic                 r_rd_pub;     // publish r_rx on the next cycle
   logic                 r_ack_smp;    // SDA level sampled in the last ACK slot
   logic                 r_scl;
   logic                 r_sda;
   logic [DATA_SZ-1:0]   r_data_rd;
   logic                 r_busy;
   logic                 r_done;
   logic                 r_ack_fl;

   logic                 w_hold;
   logic                 w_in_slot;

   // States whose q2/q3 count as "SCL high, may be stretched by the slave".
   assign w_in_slot = (r_state != ST_IDLE) && (r_state != ST_START);

`ifdef CLK_STRETCH_EN
   // Freeze timing while we release SCL in q2/q3 but the line still reads low.
   always_comb begin : stretch_detect
      w_hold = 1'b0;
      if (w_in_slot && r_phase[1] && r_scl && !I_SCL) begin
         w_hold = 1'b1;
      end
   end
`else
   logic w_unused_scl;
   assign w_unused_scl = I_SCL ^ w_in_slot;
   assign w_hold       = 1'b0;
`endif

   // Bus sequencer: quarter timing, state transitions, shift registers and
   // registered SCL/SDA drive, all advanced from one clocked process.
   always_ff @(posedge CLK or posedge RST) begin : fsm
      if (RST) begin
         r_state    <= ST_IDLE;
         r_qcnt     <= '0;
         r_phase    <= 2'd0;
         r_bitcnt   <= '0;
         r_byte_sel <= 1'b0;
         r_rw       <= 1'b0;
         r_addr_reg <= '0;
         r_data_wr  <= '0;
         r_tx       <= '0;
         r_rx       <= '0;
         r_rd_pub   <= 1'b0;
         r_ack_smp  <= 1'b0;
         r_scl      <= 1'b1;
         r_sda      <= 1'b1;
         r_data_rd  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_ack_fl   <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // The read byte becomes visible one cycle after its last bit is sampled.
         if (r_rd_pub) begin
            r_data_rd <= r_rx;
            r_rd_pub  <= 1'b0;
         end

         if (r_state == ST_IDLE) begin
            if (I_START) begin
               r_rw       <= I_RW;
               r_addr_reg <= I_ADDR_REG;
               r_data_wr  <= I_DATA_WR;
               r_tx       <= {I_ADDR_SLV, I_RW};
               r_ack_fl   <= 1'b0;
               r_ack_smp  <= 1'b0;
               r_qcnt     <= '0;
               r_phase    <= 2'd0;
               r_busy     <= 1'b1;
               r_scl      <= 1'b1;
               r_sda      <= 1'b1;
               r_state    <= ST_START;
            end
         end else if (!w_hold) begin
            if (r_qcnt != Q_LAST) begin
               r_qcnt <= r_qcnt + Q_ONE;
            end else begin
               // Quarter tick: step to the next quarter and set the drive it needs.
               r_qcnt  <= '0;
               r_phase <= r_phase + 2'd1;

               if (r_phase == 2'd1) begin
                  // Entering q2: SCL rises; in START, SDA falls while SCL is high.
                  r_scl <= 1'b1;
                  if (r_state == ST_START) begin
                     r_sda <= 1'b0;
                  end
               end else if (r_phase == 2'd2) begin
                  // End of q2: sample point. In STOP, SDA rises while SCL is high.
                  if (r_state == ST_STOP) begin
                     r_sda <= 1'b1;
                  end
                  if ((r_state == ST_ACK_COMM) || (r_state == ST_ACK_DATA)) begin
                     r_ack_smp <= I_SDA;
                     if (I_SDA) begin
                        r_ack_fl <= 1'b1;
                     end
                  end
                  if (r_state == ST_RD) begin
                     r_rx <= {r_rx[DATA_SZ-2:0], I_SDA};
                     if (r_bitcnt == B_ONE) begin
                        r_rd_pub <= 1'b1;
                     end
                  end
               end else if (r_phase == 2'd3) begin
                  // End of a phase: choose the next one and drive its q0 levels.
                  r_scl <= 1'b0;
                  case (r_state)
                     ST_START: begin
                        r_state  <= ST_COMM;
                        r_bitcnt <= BITS;
                        r_sda    <= r_tx[DATA_SZ-1];
                     end
                     ST_COMM, ST_WR: begin
                        if (r_bitcnt == B_ONE) begin
                           r_state  <= (r_state == ST_COMM) ? ST_ACK_COMM : ST_ACK_DATA;
                           r_bitcnt <= '0;
                           r_sda    <= 1'b1;
                        end else begin
                           r_bitcnt <= r_bitcnt - B_ONE;
                           r_tx     <= {r_tx[DATA_SZ-2:0], 1'b0};
                           r_sda    <= r_tx[DATA_SZ-2];
                        end
                     end
                     ST_ACK_COMM: begin
                        if (r_ack_smp) begin
                           r_state <= ST_STOP;
                           r_sda   <= 1'b0;
                        end else if (!r_rw) begin
                           r_state    <= ST_WR;
                           r_byte_sel <= 1'b0;
                           r_bitcnt   <= BITS;
                           r_tx       <= r_addr_reg;
                           r_sda      <= r_addr_reg[DATA_SZ-1];
                        end else begin
                           r_state  <= ST_RD;
                           r_bitcnt <= BITS;
                           r_sda    <= 1'b1;
                        end
                     end
                     ST_ACK_DATA: begin
                        if (r_ack_smp || r_byte_sel) begin
                           r_state <= ST_STOP;
                           r_sda   <= 1'b0;
                        end else begin
                           r_state    <= ST_WR;
                           r_byte_sel <= 1'b1;
                           r_bitcnt   <= BITS;
                           r_tx       <= r_data_wr;
                           r_sda      <= r_data_wr[DATA_SZ-1];
                        end
                     end
                     ST_RD: begin
                        r_sda <= 1'b1;
                        if (r_bitcnt == B_ONE) begin
                           r_state  <= ST_MSTR_ACK;
                           r_bitcnt <= '0;
                        end else begin
                           r_bitcnt <= r_bitcnt - B_ONE;
                        end
                     end
                     ST_MSTR_ACK: begin
                        r_state <= ST_STOP;
                        r_sda   <= 1'b0;
                     end
                     ST_STOP: begin
                        r_state <= ST_IDLE;
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                     default: begin
                        r_state <= ST_IDLE;
                        r_scl   <= 1'b1;
                        r_sda   <= 1'b1;
                        r_busy  <= 1'b0;
                     end
                  endcase
               end
            end
         end
      end
   end

   assign O_SCL     = r_scl;
   assign O_SDA     = r_sda;
   assign O_DATA_RD = r_data_rd;
   assign O_BUSY    = r_busy;
   assign O_DONE    = r_done;
   assign O_ACK_FL  = r_ack_fl;
   assign O_STATE   = r_state;

endmodule

// File: tb/tb_mstr_i2c_fsm.sv
// -----------------------------------------------------------------------------
// tb_mstr_i2c_fsm
// Bench for mstr_i2c_fsm with DIV = 4. A behavioural slave on the wired-AND
// bus acknowledges or refuses bytes and serves read data; a monitor decodes
// the bus into {byte, ack} records. Expected records, latency, O_ACK_FL and
// O_DATA_RD come from a transaction-level model of the protocol.
// With CLK_STRETCH_EN defined an extra clock-stretch sequence is run.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mstr_i2c_fsm;

   localparam int CLK_FRQ = 1_600_000;
   localparam int I2C_FRQ = 100_000;
   localparam int DIV     = CLK_FRQ / (4 * I2C_FRQ);

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // ---------------- DUT signals ----------------
   logic       i_start = 1'b0;
   logic [6:0] i_addr_slv = '0;
   logic       i_rw = 1'b0;
   logic [7:0] i_addr_reg = '0;
   logic [7:0] i_data_wr = '0;
   logic       o_scl, o_sda, o_busy, o_done, o_ack_fl;
   logic [7:0] o_data_rd;
   logic [3:0] o_state;

   // Slave side of the open-drain bus.
   logic slv_scl = 1'b1;
   logic slv_sda = 1'b1;
   wire  w_scl_line = o_scl & slv_scl;
   wire  w_sda_line = o_sda & slv_sda;

   mstr_i2c_fsm #(
      .DATA_SZ (8),
      .CLK_FRQ (CLK_FRQ),
      .I2C_FRQ (I2C_FRQ)
   ) dut (
      .CLK        (clk),
      .RST        (rst),
      .I_START    (i_start),
      .I_ADDR_SLV (i_addr_slv),
      .I_RW       (i_rw),
      .I_ADDR_REG (i_addr_reg),
      .I_DATA_WR  (i_data_wr),
      .I_SCL      (w_scl_line),
      .I_SDA      (w_sda_line),
      .O_SCL      (o_scl),
      .O_SDA      (o_sda),
      .O_DATA_RD  (o_data_rd),
      .O_BUSY     (o_busy),
      .O_DONE     (o_done),
      .O_ACK_FL   (o_ack_fl),
      .O_STATE    (o_state)
   );

   // ---------------- scoreboard state ----------------
   int n_vec = 0;
   int n_err = 0;
   int n_stop = 0;
   logic [8:0] exp_q[$];
   logic [8:0] obs_q[$];
   logic [7:0] mdl_rd = 8'h00;

   // Slave configuration for the current transaction.
   logic [7:0] cfg_rd = 8'h00;
   logic       cfg_na = 1'b0;
   logic       cfg_nr = 1'b0;
   logic       cfg_nd = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end
   endtask

   // ---------------- behavioural slave + bus monitor ----------------
   initial begin : bus_slave
      logic p_scl, p_sda, in_x, adr_ack, rd_mode;
      int bitn, byten;
      logic [7:0] sh;
      p_scl = 1'b1; p_sda = 1'b1; in_x = 1'b0; adr_ack = 1'b0; rd_mode = 1'b0;
      bitn = 0; byten = 0; sh = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            in_x = 1'b0;
            slv_sda = 1'b1;
            p_scl = 1'b1;
            p_sda = 1'b1;
         end else begin
            if (w_scl_line && p_scl && p_sda && !w_sda_line) begin
               in_x = 1'b1; bitn = 0; byten = 0; sh = '0; adr_ack = 1'b0; rd_mode = 1'b0;
            end else if (w_scl_line && p_scl && !p_sda && w_sda_line) begin
               if (in_x) n_stop++;
               in_x = 1'b0;
               slv_sda = 1'b1;
            end else if (w_scl_line && !p_scl && in_x) begin
               if (bitn < 8) begin
                  sh = {sh[6:0], w_sda_line};
               end else if (bitn == 8) begin
                  obs_q.push_back({sh, w_sda_line});
                  if (byten == 0) rd_mode = sh[0];
               end
               bitn++;
            end else if (!w_scl_line && p_scl && in_x) begin
               if (bitn == 9) begin
                  bitn = 0;
                  byten++;
               end
               slv_sda = 1'b1;
               if (byten == 0) begin
                  if (bitn == 8) begin
                     slv_sda = cfg_na;
                     adr_ack = !cfg_na;
                  end
               end else if (rd_mode) begin
                  if (byten == 1 && adr_ack && bitn < 8) slv_sda = cfg_rd[7-bitn];
               end else begin
                  if (byten == 1 && bitn == 8) slv_sda = cfg_nr;
                  if (byten == 2 && bitn == 8) slv_sda = cfg_nd;
               end
            end
            p_scl = w_scl_line;
            p_sda = w_sda_line;
         end
      end
   end

   // ---------------- reference model ----------------
   // Bytes on the wire: address byte, then either the read byte or the write
   // bytes up to the first refused one. Each byte costs 9 slots of 4 quarters;
   // START and STOP cost 4 quarters each.
   function automatic int model_bytes(input logic na, input logic rw, input logic nr);
      if (na) return 1;
      if (rw) return 2;
      if (nr) return 2;
      return 3;
   endfunction

   function automatic int model_cycles(input logic na, input logic rw, input logic nr);
      return (4 + 36 * model_bytes(na, rw, nr) + 4) * DIV;
   endfunction

   // ---------------- transaction driver ----------------
   task automatic run_txn(input string nm, input logic [6:0] a, input logic rw,
                          input logic [7:0] rg, input logic [7:0] dt, input logic [7:0] rdd,
                          input logic na, input logic nr, input logic nd,
                          input int exp_lat, input logic exp_fl, input logic [7:0] exp_rd,
                          input logic stretch, input logic glitch, input int rst_at);
      int n;
      logic fin;
      logic seen;
      exp_q.delete();
      obs_q.delete();
      n_stop = 0;
      exp_q.push_back({a, rw, na});
      if (!na) begin
         if (rw) begin
            exp_q.push_back({rdd, 1'b1});
         end else begin
            exp_q.push_back({rg, nr});
            if (!nr) exp_q.push_back({dt, nd});
         end
      end
      cfg_rd = rdd; cfg_na = na; cfg_nr = nr; cfg_nd = nd;

      @(negedge clk);
      i_addr_slv = a; i_rw = rw; i_addr_reg = rg; i_data_wr = dt; i_start = 1'b1;
      @(posedge clk);
      n = 0;
      @(negedge clk);
      i_start = 1'b0;
      fin = 1'b0;
      seen = 1'b0;
      while (!fin && n < 4000) begin
         if (stretch && n == 71) slv_scl = 1'b0;
         if (stretch && n == 92) slv_scl = 1'b1;
         if (glitch && n == 100) begin
            i_start = 1'b1; i_addr_slv = ~a; i_rw = ~rw; i_addr_reg = ~rg; i_data_wr = ~dt;
         end
         if (glitch && n == 101) i_start = 1'b0;
         if (n == 50) chk({nm, " busy_mid"}, 32'(o_busy), 32'd1);
         if (rst_at > 0 && n == rst_at) begin
            rst = 1'b1;
            #1;
            chk({nm, " rst_scl"}, 32'(o_scl), 32'd1);
            chk({nm, " rst_sda"}, 32'(o_sda), 32'd1);
            chk({nm, " rst_busy"}, 32'(o_busy), 32'd0);
            chk({nm, " rst_done"}, 32'(o_done), 32'd0);
            chk({nm, " rst_rd"}, 32'(o_data_rd), 32'd0);
            repeat (3) begin
               @(negedge clk);
               chk({nm, " rst_no_done"}, 32'(o_done), 32'd0);
            end
            rst = 1'b0;
            @(negedge clk);
            chk({nm, " post_rst_idle_scl"}, 32'(o_scl), 32'd1);
            fin = 1'b1;
         end else if (o_done) begin
            seen = 1'b1;
            fin = 1'b1;
         end else begin
            @(posedge clk);
            n++;
            @(negedge clk);
         end
      end
      slv_scl = 1'b1;
      if (rst_at > 0) return;
      if (!seen) begin
         chk({nm, " done_timeout"}, 32'(n), 32'(exp_lat));
         return;
      end
      chk({nm, " latency"}, 32'(n), 32'(exp_lat));
      chk({nm, " ack_fl"}, 32'(o_ack_fl), 32'(exp_fl));
      chk({nm, " data_rd"}, 32'(o_data_rd), 32'(exp_rd));
      chk({nm, " busy_end"}, 32'(o_busy), 32'd0);
      chk({nm, " lines_rel"}, {30'd0, o_scl, o_sda}, 32'd3);
      chk({nm, " stop_cnt"}, 32'(n_stop), 32'd1);
      chk({nm, " byte_cnt"}, 32'(obs_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < obs_q.size()) chk({nm, " bus_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
      end
      @(negedge clk);
      chk({nm, " done_pulse"}, 32'(o_done), 32'd0);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [6:0] a;
      logic       rw;
      logic [7:0] rg;
      logic [7:0] dt;
      logic [7:0] rdd;
      logic       na;
      logic       nr;
      logic       nd;
      int         lat;
      logic       fl;
      logic [7:0] rd;
   } vec_t;

   vec_t tbl[7];

   // Global time bound.
   initial begin : watchdog
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [6:0] ra;
      logic rrw, rna, rnr, rnd;
      logic [7:0] rrg, rdt, rrd;
      logic efl;

      tbl[0] = '{7'h5A, 1'b0, 8'h10, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0, 464, 1'b0, 8'h00};
      tbl[1] = '{7'h21, 1'b1, 8'h00, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 320, 1'b0, 8'hA5};
      tbl[2] = '{7'h33, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 176, 1'b1, 8'hA5};
      tbl[3] = '{7'h5A, 1'b0, 8'h77, 8'h88, 8'h00, 1'b0, 1'b1, 1'b0, 320, 1'b1, 8'hA5};
      tbl[4] = '{7'h12, 1'b0, 8'hAB, 8'hCD, 8'h00, 1'b0, 1'b0, 1'b1, 464, 1'b1, 8'hA5};
      tbl[5] = '{7'h7F, 1'b0, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 176, 1'b1, 8'hA5};
      tbl[6] = '{7'h00, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 464, 1'b0, 8'hA5};

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset_scl", 32'(o_scl), 32'd1);
      chk("reset_sda", 32'(o_sda), 32'd1);
      chk("reset_rd", 32'(o_data_rd), 32'd0);
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_done", 32'(o_done), 32'd0);
      chk("reset_ackfl", 32'(o_ack_fl), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", 32'(o_busy), 32'd0);

      // Directed table.
      for (int i = 0; i < 7; i++) begin
         run_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].rw, tbl[i].rg, tbl[i].dt, tbl[i].rdd,
                 tbl[i].na, tbl[i].nr, tbl[i].nd, tbl[i].lat, tbl[i].fl, tbl[i].rd,
                 1'b0, 1'b0, 0);
      end
      mdl_rd = 8'hA5;

      // Request pulsed while busy with different inputs: transfer unaffected.
      run_txn("busy_start", 7'h5A, 1'b0, 8'h10, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0,
              464, 1'b0, mdl_rd, 1'b0, 1'b1, 0);

      // Reset in the middle of a write.
      run_txn("mid_reset", 7'h5A, 1'b0, 8'h10, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0,
              464, 1'b0, mdl_rd, 1'b0, 1'b0, 200);
      mdl_rd = 8'h00;

`ifdef CLK_STRETCH_EN
      // Slave stretches SCL for 20 cycles in q2 of address bit 3.
      run_txn("stretch", 7'h5A, 1'b0, 8'h10, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b0,
              464 + 20, 1'b0, mdl_rd, 1'b1, 1'b0, 0);
`endif

      // Randomized transactions against the model.
      for (int k = 0; k < 12; k++) begin
         ra  = 7'($urandom_range(0, 127));
         rrw = 1'($urandom_range(0, 1));
         rrg = 8'($urandom_range(0, 255));
         rdt = 8'($urandom_range(0, 255));
         rrd = 8'($urandom_range(0, 255));
         rna = ($urandom_range(0, 3) == 0);
         rnr = ($urandom_range(0, 3) == 0);
         rnd = ($urandom_range(0, 3) == 0);
         efl = rna || (!rrw && (rnr || rnd));
         if (!rna && rrw) mdl_rd = rrd;
         run_txn($sformatf("rnd%0d", k), ra, rrw, rrg, rdt, rrd, rna, rnr, rnd,
                 model_cycles(rna, rrw, rnr), efl, mdl_rd, 1'b0, 1'b0, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mstr_i2c_fsm.md
Name: mstr_i2c_fsm

Overview:
- Single-master I2C bus controller that drives the initiator end of the link served by the team's I2C slave FSM.
- Takes a transaction request from local logic and generates START, then the 7-bit address plus RW.
- Write transaction: sends a register-address byte, then a data byte.
- Read transaction: reads one data byte and answers it with master NACK.
- Ends every transaction with STOP and reports slave NACKs.
- SCL/SDA outputs are open-drain style: 1 = release, 0 = drive low. Pads and synchronisers sit outside this block.

Parameters:
DATA_SZ, 8, byte width; the address field is DATA_SZ-1 bits.
CLK_FRQ, 50_000_000, CLK frequency in Hz.
I2C_FRQ, 100_000, SCL frequency in Hz; quarter-period divider DIV = CLK_FRQ/(4*I2C_FRQ), and must be >= 1.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous reset, active-high
I_START  in  1  transaction request pulse; sampled only in IDLE
I_ADDR_SLV  in  DATA_SZ-1  slave address
I_RW  in  1  0 = write, 1 = read
I_ADDR_REG  in  DATA_SZ  register address byte (write only)
I_DATA_WR  in  DATA_SZ  data byte (write only)
I_SCL  in  1  synchronised SCL line level
I_SDA  in  1  synchronised SDA line level
O_SCL  out  1  SCL drive (1 = release)
O_SDA  out  1  SDA drive (1 = release)
O_DATA_RD  out  DATA_SZ  byte read from the slave
O_BUSY  out  1  high in every state except IDLE
O_DONE  out  1  one-cycle pulse on return to IDLE
O_ACK_FL  out  1  slave NACK seen in the last transaction

Behaviour:
- Reset values: O_SCL=1, O_SDA=1, O_DATA_RD=0, O_BUSY=0, O_DONE=0, O_ACK_FL=0, state IDLE, all counters 0.
- Asserting RST mid-transaction releases both lines at once, with no STOP and no O_DONE.
- Request acceptance: in IDLE, I_START=1 latches I_ADDR_SLV, I_RW, I_ADDR_REG and I_DATA_WR.
  - On acceptance: O_ACK_FL is cleared, the quarter counter is zeroed, and the state moves to START on the next edge.
  - I_START while busy is ignored; the latched inputs are not disturbed.
- Timing base: the quarter counter counts 0..DIV-1 and issues a tick at DIV-1. Every bus phase is 4 quarters, q0..q3, each lasting DIV cycles.
- START: q0 and q1 have SCL=1, SDA=1; q2 and q3 have SCL=1, SDA=0.
- Bit slot (all data and ACK bits):
  - q0 and q1: SCL=0; SDA is updated at the start of q0.
  - q2 and q3: SCL=1.
  - I_SDA is sampled on the tick that ends q2.
- States and transitions:
  - IDLE -> START -> COMM.
  - COMM: sends {addr, RW} MSB first, 8 slots, then goes to ACK_COMM.
  - ACK_COMM: SDA released for 1 slot.
    - Sampled 1 -> O_ACK_FL=1, go to STOP.
    - Else if RW=0 -> WR sending ADDR_REG.
    - Else -> RD.
  - WR: 8 slots, then ACK_DATA (SDA released, 1 slot).
    - NACK -> O_ACK_FL=1, go to STOP.
    - ACK after ADDR_REG -> WR sending DATA_WR.
    - ACK after DATA_WR -> STOP.
  - RD: SDA released for 8 slots, sampled bits shift in MSB first. O_DATA_RD updates in the cycle after the 8th sample. Then MSTR_ACK.
  - MSTR_ACK: SDA=1 (NACK) for 1 slot, then STOP.
  - STOP: q0 and q1 have SCL=0, SDA=0; q2 has SCL=1, SDA=0; q3 has SCL=1, SDA=1. At the end of q3 go to IDLE and pulse O_DONE.
- Latency from the acceptance edge to the O_DONE pulse:
  - Write: 116 quarters.
  - Read: 80 quarters.
  - Address NACK: 44 quarters.
  - Data NACK on the register byte: 80 quarters.
- Bit counter: DATA_SZ down to 0; no wrap. The byte-select flag distinguishes ADDR_REG from DATA_WR.
- SDA transitions only while SCL=0, except the START and STOP edges.
- O_DATA_RD holds its value until the next completed read. It is not cleared by a write or by a NACK.

Optional Feature:
- CLK_STRETCH_EN defined:
  - In q2 and q3 of any slot and of STOP, if I_SCL=0 while O_SCL=1, the quarter counter and phase hold.
  - Timing resumes on the first cycle I_SCL reads 1, so latency grows by exactly the stretched cycles.
- CLK_STRETCH_EN undefined: I_SCL is ignored and timing is fixed.

Test Plan:
- Bench parameters: CLK_FRQ=1_600_000, I2C_FRQ=100_000, so DIV=4.
- Write, slave ACKs all: addr=7'h5A, RW=0, REG=8'h10, DATA=8'hC3 -> bytes B4, 10, C3 seen on the bus; O_DONE 464 cycles after acceptance; O_ACK_FL=0.
- Read, slave ACKs the address and drives 8'hA5: addr=7'h21, RW=1 -> byte 43 on the bus; O_DATA_RD=A5; master NACK (SDA high) in the 9th slot; O_DONE at 320 cycles.
- Address NACK (SDA left high): -> O_ACK_FL=1; STOP generated; O_DONE at 176 cycles; no further bytes.
- I_START pulsed mid-write with different data; RST asserted at cycle 200 of a second write -> first transfer unaffected; after RST, O_SCL=O_SDA=1 immediately, no O_DONE, O_BUSY=0.
- CLK_STRETCH_EN: hold I_SCL low for 20 cycles during the q2 of bit 3 of the address -> O_DONE delayed by exactly 20 cycles; data unchanged.
